ddr3_request_arbiter: RTL

Round-robin arbiter and command sequencer that shares the single user port of the DDR3 memory controller among several on-chip requesters. It accepts read/write requests over per-requester valid/ready handshakes, issues exactly one command at a time to the controller, tracks the single outstanding read, and routes the returned data, or a timeout error, back to the requester that issued it. It sits between the user logic and `ddr3_memory_controller`.

---
 rtl/ddr3_request_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ddr3_request_arbiter.sv
// Round-robin arbiter and single-command sequencer in front of the DDR3 controller user port.
// One command in flight at a time; read data or a timeout error is routed back to the owner.
//
// state     | meaning
// S_IDLE    | waiting for any req_valid; grants and latches one request combinationally
// S_ISSUE   | presenting the latched command until mem_ready
// S_WAIT_RD | waiting for read data, counting towards READ_TIMEOUT
module ddr3_request_arbiter #(
    parameter int NUM_REQUESTERS        = 4,
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int READ_TIMEOUT          = 255
) (
    input  logic                                                              clk,
    input  logic                                                              resetn,
    input  logic [NUM_REQUESTERS-1:0]                                         req_valid,
    input  logic [NUM_REQUESTERS-1:0]                                         req_write,
    input  logic [NUM_REQUESTERS*(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH)-1:0] req_address,
    input  logic [NUM_REQUESTERS*DQ_BITWIDTH-1:0]                             req_wdata,
    output logic [NUM_REQUESTERS-1:0]                                         req_ready,
    output logic [NUM_REQUESTERS-1:0]                                         rsp_valid,
    output logic [DQ_BITWIDTH-1:0]                                            rsp_data,
    output logic                                                              rsp_error,
    output logic                                                              busy,
    output logic                                                              mem_write_enable,
    output logic                                                              mem_read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0]                 mem_address,
    output logic [DQ_BITWIDTH-1:0]                                            mem_wdata,
    input  logic                                                              mem_ready,
    input  logic [DQ_BITWIDTH-1:0]                                            mem_rdata,
    input  logic                                                              mem_rdata_valid
);

    localparam int N  = NUM_REQUESTERS;
    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int DW = DQ_BITWIDTH;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic          grant_found;
    logic          accept;
    logic          is_write;
    logic [CW-1:0] rd_cnt;
    logic          rd_tmo;

    // Search upward from the requester after the last winner, wrapping; last probe is rr_ptr itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(rr_ptr) + i) % N);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_found;
    assign rd_tmo = (rd_cnt == CW'(READ_TIMEOUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_found) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_ready) state_nxt = is_write ? S_IDLE : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (mem_rdata_valid || rd_tmo) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready        = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) req_ready[grant_idx] = 1'b1;
            end
            S_ISSUE: begin
                mem_write_enable = is_write;
                mem_read_enable  = !is_write;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr      <= PW'(N - 1);
            owner       <= '0;
            is_write    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rd_cnt      <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                owner       <= grant_idx;
                is_write    <= req_write[grant_idx];
                mem_address <= req_address[int'(grant_idx)*AW +: AW];
                mem_wdata   <= req_wdata[int'(grant_idx)*DW +: DW];
                rr_ptr      <= grant_idx;
            end
            if (state == S_ISSUE && mem_ready) begin
                rd_cnt <= '0;
            end else if (state == S_WAIT_RD) begin
                rd_cnt <= rd_cnt + CW'(1);
            end
            // Data returning on the timeout cycle still counts as a good read.
            if (state == S_WAIT_RD) begin
                if (mem_rdata_valid) begin
                    rsp_valid <= N'(1) << owner;
                    rsp_data  <= mem_rdata;
                    rsp_error <= 1'b0;
                end else if (rd_tmo) begin
                    rsp_valid <= N'(1) << owner;
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                end
            end
        end
    end

endmodule
